// File: rtl/systolic_window_feeder.sv
// -----------------------------------------------------------------------------
// systolic_window_feeder
//
// Turns a raster-order pixel stream into KERNEL_SIZE x KERNEL_SIZE sliding
// windows for a systolic datapath. KERNEL_SIZE-1 line buffers hold the
// previous rows. A KxK column-register array shifts left on every accepted
// pixel. That array is the window output register.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid && ready are both high. Upstream holds in_pixel stable while in_valid
// is high and in_ready is low. The window side keeps window, frame_start and
// frame_done stable while window_valid is high and out_ready is low.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     upstream pixel valid
//   in_ready     feeder can accept a pixel (= !window_valid || out_ready)
//   in_pixel     pixel, row-major, column 0 first
//   out_ready    downstream accepts the window
//   window       element (r,c) at [(r*K+c)*DATA_W +: DATA_W];
//                r=0 is the oldest row, c=0 is the leftmost column
//   window_valid window holds a complete KxK window
//   frame_start  first window of a frame (qualified by window_valid)
//   frame_done   last window of a frame (qualified by window_valid)
//
// Optional build macro WIN_COORD_EN adds these outputs:
//   win_row, win_col  bottom-right pixel position of the current window
// -----------------------------------------------------------------------------
module systolic_window_feeder #(
  parameter int IMG_WIDTH   = 3,
  parameter int IMG_HEIGHT  = 6,
  parameter int KERNEL_SIZE = 2,
  parameter int DATA_W      = 8,
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [DATA_W-1:0]                         in_pixel,
  input  logic                                      out_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_W-1:0] window,
  output logic                                      window_valid,
  output logic                                      frame_start,
  output logic                                      frame_done
`ifdef WIN_COORD_EN
  ,
  output logic [RW-1:0]                             win_row,
  output logic [CW-1:0]                             win_col
`endif
);

  localparam int K = KERNEL_SIZE;

  // Index 0 is the oldest row and index K-2 is the row just above the
  // current one.
  logic [DATA_W-1:0] r_lb  [K-1][IMG_WIDTH];
  logic [DATA_W-1:0] r_win [K][K];

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_valid;
  logic          r_start;
  logic          r_done;

  logic w_accept;
  logic w_release;
  logic w_col_last;
  logic w_row_last;
  logic w_win_pos;

  // Single output register stage. A window leaving in the same cycle frees
  // the slot, so continuous flow has no bubble.
  assign in_ready   = !r_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_release  = r_valid && out_ready;
  assign w_col_last = (r_col == CW'(IMG_WIDTH - 1));
  assign w_row_last = (r_row == RW'(IMG_HEIGHT - 1));
  // The pixel being accepted completes a window when it is at least K-1 rows
  // down and K-1 columns across.
  assign w_win_pos  = (r_row >= RW'(K - 1)) && (r_col >= CW'(K - 1));

  // Line buffers carry no reset. Stale contents only reach the window while
  // window_valid is low.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int r = 0; r < K - 2; r++) begin
        r_lb[r][r_col] <= r_lb[r+1][r_col];
      end
      r_lb[K-2][r_col] <= in_pixel;
    end
  end

  // Column-register array: shift left, then load the new right-hand column
  // from the line buffers (old values) plus the incoming pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          r_win[r][c] <= r_win[r][c+1];
        end
      end
      for (int r = 0; r < K - 1; r++) begin
        r_win[r][K-1] <= r_lb[r][r_col];
      end
      r_win[K-1][K-1] <= in_pixel;
    end
  end

  // Raster counters and window qualifiers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
      r_valid <= w_win_pos;
      r_start <= w_win_pos && (r_row == RW'(K - 1)) && (r_col == CW'(K - 1));
      r_done  <= w_win_pos && w_row_last && w_col_last;
    end else if (w_release) begin
      r_valid <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
    end
  end

`ifdef WIN_COORD_EN
  logic [RW-1:0] r_win_row;
  logic [CW-1:0] r_win_col;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_row <= '0;
      r_win_col <= '0;
    end else if (w_accept && w_win_pos) begin
      r_win_row <= r_row;
      r_win_col <= r_col;
    end
  end

  assign win_row = r_win_row;
  assign win_col = r_win_col;
`endif

  for (genvar gr = 0; gr < K; gr++) begin : g_row
    for (genvar gc = 0; gc < K; gc++) begin : g_col
      assign window[(gr*K+gc)*DATA_W +: DATA_W] = r_win[gr][gc];
    end
  end

  assign window_valid = r_valid;
  assign frame_start  = r_start;
  assign frame_done   = r_done;

endmodule

// File: tb/tb_systolic_window_feeder.sv
// -----------------------------------------------------------------------------
// Testbench for systolic_window_feeder.
//   dut  : default parameters (3 x 6 image, K=2, 8-bit pixels)
//   dut3 : 3 x 3 image with K=3 (single-window frame)
// The expected windows are hand-written constants in exp_entry().
// -----------------------------------------------------------------------------
module tb_systolic_window_feeder;

  localparam int EXP_W = 39; // {window[31:0], start, done, row[2:0], col[1:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- default DUT ----------------
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pixel;
  logic        out_ready;
  logic [31:0] window;
  logic        window_valid;
  logic        frame_start;
  logic        frame_done;
`ifdef WIN_COORD_EN
  logic [2:0]  win_row;
  logic [1:0]  win_col;
`endif

  systolic_window_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pixel     (in_pixel),
    .out_ready    (out_ready),
    .window       (window),
    .window_valid (window_valid),
    .frame_start  (frame_start),
    .frame_done   (frame_done)
`ifdef WIN_COORD_EN
    ,
    .win_row      (win_row),
    .win_col      (win_col)
`endif
  );

  // ---------------- K=3 DUT ----------------
  logic        in_valid3;
  logic        in_ready3;
  logic [7:0]  in_pixel3;
  logic        out_ready3;
  logic [71:0] window3;
  logic        window_valid3;
  logic        frame_start3;
  logic        frame_done3;
`ifdef WIN_COORD_EN
  logic [1:0]  win_row3;
  logic [1:0]  win_col3;
`endif

  systolic_window_feeder #(
    .IMG_WIDTH   (3),
    .IMG_HEIGHT  (3),
    .KERNEL_SIZE (3),
    .DATA_W      (8)
  ) dut3 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid3),
    .in_ready     (in_ready3),
    .in_pixel     (in_pixel3),
    .out_ready    (out_ready3),
    .window       (window3),
    .window_valid (window_valid3),
    .frame_start  (frame_start3),
    .frame_done   (frame_done3)
`ifdef WIN_COORD_EN
    ,
    .win_row      (win_row3),
    .win_col      (win_col3)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic             exp_valid;
  int               n_assert = 0;
  int               n_fail   = 0;
  int               pix_idx;
  int               n_start;
  int               n_done;

  // Hand-computed windows of one 3x6 frame with pixel = row*3+col.
  // Window bytes from MSB: (1,1),(1,0),(0,1),(0,0).
  function automatic logic [EXP_W-1:0] exp_entry(input int k);
    logic [EXP_W-1:0] e;
    case (k)
      0:       e = {32'h04030100, 1'b1, 1'b0, 3'd1, 2'd1};
      1:       e = {32'h05040201, 1'b0, 1'b0, 3'd1, 2'd2};
      2:       e = {32'h07060403, 1'b0, 1'b0, 3'd2, 2'd1};
      3:       e = {32'h08070504, 1'b0, 1'b0, 3'd2, 2'd2};
      4:       e = {32'h0A090706, 1'b0, 1'b0, 3'd3, 2'd1};
      5:       e = {32'h0B0A0807, 1'b0, 1'b0, 3'd3, 2'd2};
      6:       e = {32'h0D0C0A09, 1'b0, 1'b0, 3'd4, 2'd1};
      7:       e = {32'h0E0D0B0A, 1'b0, 1'b0, 3'd4, 2'd2};
      8:       e = {32'h100F0D0C, 1'b0, 1'b0, 3'd5, 2'd1};
      default: e = {32'h11100E0D, 1'b0, 1'b1, 3'd5, 2'd2};
    endcase
    return e;
  endfunction

  // A pixel completes a window when it is on row >= 1 and column >= 1.
  function automatic logic pos_is_window(input int p);
    int f;
    f = p % 18;
    return ((f / 3) >= 1) && ((f % 3) >= 1);
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int first, input int last);
    for (int k = first; k <= last; k++) exp_q.push_back(exp_entry(k));
  endtask

  task automatic check_release();
    logic [EXP_W-1:0] e;
    n_assert++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL window_count: observed extra window %0h, expected none", window);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("window", 72'(window), 72'(e[38:7]));
      chk("frame_start", 72'(frame_start), 72'(e[6]));
      chk("frame_done", 72'(frame_done), 72'(e[5]));
`ifdef WIN_COORD_EN
      chk("win_row", 72'(win_row), 72'(e[4:2]));
      chk("win_col", 72'(win_col), 72'(e[1:0]));
`endif
      if (frame_start) n_start++;
      if (frame_done)  n_done++;
    end
  endtask

  // One clock: sample at the falling edge, advance the model at the rising one.
  task automatic cycle();
    logic acc;
    logic rel;
    @(negedge clk);
    chk("in_ready", 72'(in_ready), 72'(!exp_valid || out_ready));
    chk("window_valid", 72'(window_valid), 72'(exp_valid));
    acc = in_valid && in_ready && !rst;
    rel = window_valid && out_ready && !rst;
    if (rel) check_release();
    @(posedge clk);
    #1;
    if (rst) begin
      exp_valid = 1'b0;
    end else if (acc) begin
      exp_valid = pos_is_window(pix_idx);
      pix_idx++;
    end else if (rel) begin
      exp_valid = 1'b0;
    end
    in_pixel = 8'(pix_idx % 18);
  endtask

  // Streams npix pixels (value = index mod 18). Optionally randomises
  // in_valid, and optionally stalls 3 cycles on window {1,2,4,5}.
  task automatic run_stream(input int npix, input bit rand_valid, input bit do_stall);
    int cyc;
    bit stalled;
    pix_idx  = 0;
    in_pixel = 8'd0;
    cyc      = 0;
    stalled  = 1'b0;
    while (pix_idx < npix && cyc < 4000) begin
      if (do_stall && !stalled && window_valid && window === 32'h05040201) begin
        stalled   = 1'b1;
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          in_valid = 1'b1;
          cycle();
          chk("stall_window", 72'(window), 72'h05040201);
          chk("stall_in_ready", 72'(in_ready), 72'd0);
          chk("stall_valid", 72'(window_valid), 72'd1);
        end
        out_ready = 1'b1;
      end
      in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      cyc++;
    end
    in_valid = 1'b0;
    n_assert++;
    assert (pix_idx == npix) else begin
      n_fail++;
      $error("FAIL stream_timeout: observed %0d pixels expected %0d", pix_idx, npix);
    end
    if (do_stall) chk("stall_seen", 72'(stalled), 72'd1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    cycle();
    cycle();
    chk("queue_empty", 72'(exp_q.size()), 72'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p3;
    int w3;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_pixel   = 8'd0;
    out_ready  = 1'b1;
    in_valid3  = 1'b0;
    in_pixel3  = 8'd0;
    out_ready3 = 1'b1;
    exp_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_window", 72'(window), 72'd0);
    chk("rst_window_valid", 72'(window_valid), 72'd0);
    chk("rst_frame_start", 72'(frame_start), 72'd0);
    chk("rst_frame_done", 72'(frame_done), 72'd0);
    chk("rst_in_ready", 72'(in_ready), 72'd1);
    chk("rst_window_valid3", 72'(window_valid3), 72'd0);
`ifdef WIN_COORD_EN
    chk("rst_win_row", 72'(win_row), 72'd0);
    chk("rst_win_col", 72'(win_col), 72'd0);
`endif
    rst = 1'b0;

    // Continuous frame
    n_start = 0;
    n_done  = 0;
    push_frame(0, 9);
    run_stream(18, 1'b0, 1'b0);
    drain();
    chk("f1_starts", 72'(n_start), 72'd1);
    chk("f1_dones", 72'(n_done), 72'd1);

    // Backpressure on window {1,2,4,5}
    push_frame(0, 9);
    run_stream(18, 1'b0, 1'b1);
    drain();

    // Random in_valid over two back-to-back frames
    n_start = 0;
    n_done  = 0;
    push_frame(0, 9);
    push_frame(0, 9);
    run_stream(36, 1'b1, 1'b0);
    drain();
    chk("rand_starts", 72'(n_start), 72'd2);
    chk("rand_dones", 72'(n_done), 72'd2);

    // Reset mid-frame after pixel 8; window {4,5,7,8} is pending and discarded
    push_frame(0, 2);
    run_stream(9, 1'b0, 1'b0);
    chk("pre_rst_valid", 72'(window_valid), 72'd1);
    rst       = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    cycle();
    rst       = 1'b0;
    out_ready = 1'b1;
    chk("post_rst_valid", 72'(window_valid), 72'd0);
    chk("post_rst_window", 72'(window), 72'd0);
    chk("post_rst_in_ready", 72'(in_ready), 72'd1);
    chk("post_rst_queue", 72'(exp_q.size()), 72'd0);
    n_start = 0;
    n_done  = 0;
    push_frame(0, 9);
    run_stream(18, 1'b0, 1'b0);
    drain();
    chk("restream_starts", 72'(n_start), 72'd1);
    chk("restream_dones", 72'(n_done), 72'd1);

    // K=3 on a 3x3 image: exactly one window, bytes 0..8 in (r,c) order
    p3 = 0;
    w3 = 0;
    for (int c = 0; c < 14; c++) begin
      in_valid3 = (p3 < 9);
      in_pixel3 = 8'(p3);
      @(negedge clk);
      if (window_valid3) begin
        w3++;
        chk("k3_window", window3, 72'h080706050403020100);
        chk("k3_frame_start", 72'(frame_start3), 72'd1);
        chk("k3_frame_done", 72'(frame_done3), 72'd1);
`ifdef WIN_COORD_EN
        chk("k3_win_row", 72'(win_row3), 72'd2);
        chk("k3_win_col", 72'(win_col3), 72'd2);
`endif
      end
      @(posedge clk);
      #1;
      if (in_valid3 && in_ready3) p3++;
    end
    in_valid3 = 1'b0;
    chk("k3_pixels", 72'(p3), 72'd9);
    chk("k3_window_count", 72'(w3), 72'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
